imem_boot_loader: RTL and testbench

Streams a program image into the core's 64-word instruction memory over a byte-wide valid/ready link. It holds the core in reset until the whole image is loaded and verified. It sits directly upstream of instruction memory: it is the only writer of that memory, and its `core_run` output gates the core's reset. Each image is a 16-bit little-endian word count, then the words as little-endian bytes, then one XOR checksum byte.

---
 rtl/imem_boot_loader_pkg.sv | 19 +
 rtl/imem_boot_loader_if.sv | 29 ++
 rtl/imem_boot_loader_byte_packer.sv | 52 +++++
 rtl/imem_boot_loader.sv | 126 ++++++++++++
 tb/tb_imem_boot_loader.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/imem_boot_loader_pkg.sv
// boot_pkg: shared types and constants for the instruction-memory boot loader.
//   - boot_state_e : loader state machine encoding
//   - HDR_BYTES    : bytes in the little-endian word-count header
//   - WORD_BYTES   : bytes per instruction word
package boot_pkg;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    LEN_LO = 3'd0,
    LEN_HI = 3'd1,
    DATA   = 3'd2,
    CSUM   = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } boot_state_e;

endpackage

// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if: byte-stream input link plus instruction-memory write
// port and status of the boot loader.
//   rx_valid/rx_data/rx_ready : byte-wide valid/ready image stream
//   imem_we/imem_addr/imem_wdata : one-cycle word write to instruction memory
//   loaded_words, core_run, err : load progress and result
// Modports: slave = the loader, master = the image source / observer.
interface imem_boot_loader_if #(
  parameter int ADDR_W = 6
) ();
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   loaded_words;
  logic              core_run;
  logic              err;

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata, loaded_words, core_run, err
  );

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata, loaded_words, core_run, err
  );
endinterface

// File: rtl/imem_boot_loader_byte_packer.sv
// byte_packer: assembles accepted bytes into 32-bit words, little-endian.
//   clk, reset        : clock, asynchronous active-low reset
//   byte_valid_i      : a data byte is accepted this cycle
//   byte_i            : the accepted byte
//   word_done_o       : combinational, this byte completes a word
//   word_valid_o      : registered one-cycle pulse after a word completes
//   word_o            : registered assembled word, held until the next one
module byte_packer
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_done_o,
  output logic        word_valid_o,
  output logic [31:0] word_o
);
  localparam int CNT_W = $clog2(WORD_BYTES);

  logic [CNT_W-1:0] cnt_q;
  logic [23:0]      part_q;
  logic [31:0]      word_q;
  logic             valid_q;

  assign word_done_o  = byte_valid_i && (cnt_q == CNT_W'(WORD_BYTES - 1));
  assign word_valid_o = valid_q;
  assign word_o       = word_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      part_q  <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (byte_valid_i) begin
        // Counter wraps 3->0 naturally at its 2-bit width.
        cnt_q <= cnt_q + 1'b1;
        if (word_done_o) begin
          // Last byte goes straight into the top lane; the word is
          // never assembled from a stale top byte.
          word_q  <= {byte_i, part_q};
          valid_q <= 1'b1;
        end else begin
          part_q[{cnt_q, 3'b000} +: 8] <= byte_i;
        end
      end
    end
  end
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a program image (16-bit LE word count, LE words,
// XOR checksum byte) into instruction memory and releases the core only
// after the whole image is written and the checksum matches.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : imem_boot_loader_if.slave (byte stream in, memory write
//                port, loaded_words / core_run / err status out)
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  imem_boot_loader_if.slave  bus
);
  boot_state_e       state_q;
  logic [7:0]        cnt_lo_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   idx_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        csum_q;
  logic              rx_ready_q;
  logic              core_run_q;
  logic              err_q;

  logic              accept;
  logic              word_done;
  logic [ADDR_W:0]   idx_inc;
  logic [15:0]       count_full;

  assign accept     = bus.rx_valid && rx_ready_q;
  assign idx_inc    = idx_q + 1'b1;
  assign count_full = {bus.rx_data, cnt_lo_q};

  byte_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .byte_valid_i (accept && (state_q == DATA)),
    .byte_i       (bus.rx_data),
    .word_done_o  (word_done),
    .word_valid_o (bus.imem_we),
    .word_o       (bus.imem_wdata)
  );

  assign bus.rx_ready     = rx_ready_q;
  assign bus.imem_addr    = addr_q;
  assign bus.loaded_words = idx_q;
  assign bus.core_run     = core_run_q;
  assign bus.err          = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= LEN_LO;
      cnt_lo_q   <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      addr_q     <= '0;
      csum_q     <= '0;
      rx_ready_q <= 1'b0;
      core_run_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // Address and word count advance on the edge that raises imem_we.
      if (word_done) begin
        addr_q <= idx_q[ADDR_W-1:0];
        idx_q  <= idx_inc;
      end

      case (state_q)
        LEN_LO: begin
          rx_ready_q <= 1'b1;
          if (accept) begin
            cnt_lo_q <= bus.rx_data;
            csum_q   <= csum_q ^ bus.rx_data;
            state_q  <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (accept) begin
            csum_q <= csum_q ^ bus.rx_data;
            if (count_full > 16'(DEPTH)) begin
              state_q    <= ERR;
              err_q      <= 1'b1;
              rx_ready_q <= 1'b0;
            end else if (count_full == 16'd0) begin
              state_q <= CSUM;
            end else begin
              count_q <= count_full[ADDR_W:0];
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            csum_q <= csum_q ^ bus.rx_data;
            // ADDR_W+1-bit compare so a full DEPTH-word image terminates.
            if (word_done && (idx_inc == count_q)) begin
              state_q <= CSUM;
            end
          end
        end
        CSUM: begin
          if (accept) begin
            rx_ready_q <= 1'b0;
            if (bus.rx_data == csum_q) begin
              state_q    <= DONE;
              core_run_q <= 1'b1;
            end else begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end
          end
        end
        DONE, ERR: begin
          rx_ready_q <= 1'b0;
        end
        default: begin
          state_q    <= ERR;
          err_q      <= 1'b1;
          rx_ready_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed-vector bench for imem_boot_loader. Drives
// image bytes over the valid/ready link, records every memory write at the
// falling edge, and compares against hand-computed expectations.
module tb_imem_boot_loader;
  import boot_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  imem_boot_loader_if #(.ADDR_W(6)) bus ();

  imem_boot_loader #(.DEPTH(64), .ADDR_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int stalls = 0;
  int wr_n = 0;
  logic [5:0]  wr_addr [0:255];
  logic [31:0] wr_data [0:255];
  int          wr_cyc  [0:255];

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: imem_we is a full-cycle pulse, so one falling edge per write.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1 && wr_n < 256) begin
      wr_addr[wr_n] <= bus.imem_addr;
      wr_data[wr_n] <= bus.imem_wdata;
      wr_cyc[wr_n]  <= cyc;
      wr_n          <= wr_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer one byte; returns 1 time unit after the edge that accepted it.
  task automatic send_byte(input logic [7:0] b);
    int waits;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    waits = 0;
    while (bus.rx_ready !== 1'b1 && waits < 20) begin
      @(posedge clk); #1;
      waits++;
      stalls++;
    end
    if (waits >= 20) begin
      check("ready_timeout", {31'd0, bus.rx_ready}, 32'd1);
    end else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic idle();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  // Asserts reset right now (possibly mid-cycle), checks the asynchronous
  // return to reset values, then releases and checks rx_ready rising.
  task automatic do_reset();
    reset = 1'b0;
    idle();
    #1;
    check("rst_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
    check("rst_imem_we", {31'd0, bus.imem_we}, 32'd0);
    check("rst_imem_addr", {26'd0, bus.imem_addr}, 32'd0);
    check("rst_imem_wdata", bus.imem_wdata, 32'd0);
    check("rst_loaded", {25'd0, bus.loaded_words}, 32'd0);
    check("rst_core_run", {31'd0, bus.core_run}, 32'd0);
    check("rst_err", {31'd0, bus.err}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_ready_rise", {31'd0, bus.rx_ready}, 32'd1);
  endtask

  // Header 02 00 followed by the first ndata bytes of the two-word image.
  task automatic load_two(input int ndata);
    logic [7:0] d [8];
    d = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    send_byte(8'h02);
    send_byte(8'h00);
    for (int i = 0; i < ndata; i++) send_byte(d[i]);
  endtask

  task automatic settle();
    idle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    logic [31:0] w64 [64];
    logic [7:0] cs;
    idle();

    // ---- Test 1: good two-word image ----
    do_reset();
    base = wr_n;
    load_two(8);
    check("t1_csum_state_ready", {31'd0, bus.rx_ready}, 32'd1);
    check("t1_csum_state_run", {31'd0, bus.core_run}, 32'd0);
    send_byte(8'h92);
    check("t1_run_after_cs", {31'd0, bus.core_run}, 32'd1);
    check("t1_ready_after_cs", {31'd0, bus.rx_ready}, 32'd0);
    settle();
    check("t1_nwrites", wr_n - base, 32'd2);
    check("t1_addr0", {26'd0, wr_addr[base]}, 32'd0);
    check("t1_data0", wr_data[base], 32'h0000_0013);
    check("t1_addr1", {26'd0, wr_addr[base+1]}, 32'd1);
    check("t1_data1", wr_data[base+1], 32'h0010_0093);
    check("t1_loaded", {25'd0, bus.loaded_words}, 32'd2);
    check("t1_err", {31'd0, bus.err}, 32'd0);
    check("t1_core_run", {31'd0, bus.core_run}, 32'd1);

    // ---- Test 2: bad checksum (also checks async core_run drop) ----
    do_reset();
    base = wr_n;
    load_two(8);
    send_byte(8'h93);
    settle();
    check("t2_nwrites", wr_n - base, 32'd2);
    check("t2_err", {31'd0, bus.err}, 32'd1);
    check("t2_core_run", {31'd0, bus.core_run}, 32'd0);
    check("t2_rx_ready", {31'd0, bus.rx_ready}, 32'd0);

    // ---- Test 3: empty image ----
    do_reset();
    base = wr_n;
    send_byte(8'h00);
    send_byte(8'h00);
    check("t3_hdr_ready", {31'd0, bus.rx_ready}, 32'd1);
    send_byte(8'h00);
    check("t3_core_run", {31'd0, bus.core_run}, 32'd1);
    settle();
    check("t3_nwrites", wr_n - base, 32'd0);
    check("t3_err", {31'd0, bus.err}, 32'd0);

    // ---- Test 4: count 65 exceeds depth ----
    do_reset();
    base = wr_n;
    send_byte(8'h41);
    send_byte(8'h00);
    check("t4_err", {31'd0, bus.err}, 32'd1);
    check("t4_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
    settle();
    check("t4_nwrites", wr_n - base, 32'd0);
    check("t4_core_run", {31'd0, bus.core_run}, 32'd0);

    // ---- Test 5: full 64-word image streamed back to back ----
    do_reset();
    base = wr_n;
    stalls = 0;
    cs = 8'h40 ^ 8'h00;
    for (int i = 0; i < 64; i++) begin
      w64[i] = {8'(i * 3 + 1), 8'hA5 ^ 8'(i), 8'(i), 8'h3C};
      cs = cs ^ w64[i][7:0] ^ w64[i][15:8] ^ w64[i][23:16] ^ w64[i][31:24];
    end
    send_byte(8'h40);
    send_byte(8'h00);
    for (int i = 0; i < 64; i++) begin
      send_byte(w64[i][7:0]);
      send_byte(w64[i][15:8]);
      send_byte(w64[i][23:16]);
      send_byte(w64[i][31:24]);
    end
    send_byte(cs);
    settle();
    check("t5_nwrites", wr_n - base, 32'd64);
    for (int i = 0; i < 64; i++) begin
      check($sformatf("t5_addr%0d", i), {26'd0, wr_addr[base+i]}, 32'(i));
      check($sformatf("t5_data%0d", i), wr_data[base+i], w64[i]);
      if (i > 0) check($sformatf("t5_gap%0d", i), 32'(wr_cyc[base+i] - wr_cyc[base+i-1]), 32'd4);
    end
    check("t5_stalls", 32'(stalls), 32'd0);
    check("t5_loaded", {25'd0, bus.loaded_words}, 32'd64);
    check("t5_core_run", {31'd0, bus.core_run}, 32'd1);
    check("t5_err", {31'd0, bus.err}, 32'd0);

    // ---- Test 6: reset mid-load, then reload from address 0 ----
    do_reset();
    load_two(5);
    check("t6_mid_loaded", {25'd0, bus.loaded_words}, 32'd1);
    do_reset();
    base = wr_n;
    load_two(8);
    send_byte(8'h92);
    settle();
    check("t6_nwrites", wr_n - base, 32'd2);
    check("t6_addr0", {26'd0, wr_addr[base]}, 32'd0);
    check("t6_data0", wr_data[base], 32'h0000_0013);
    check("t6_data1", wr_data[base+1], 32'h0010_0093);
    check("t6_core_run", {31'd0, bus.core_run}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
